// File: rtl/full_adder_cell_if.sv
// rtl/full_adder_cell_if.sv - Signal bundle for one full adder cell.
//
// Purpose : groups the operand/qualifier inputs and the combinational and
//           registered results of a full_adder_cell so a cell can be passed
//           around as a single port.
// Modports:
//   master - drives a, b, cin, in_valid; observes every result signal
//   slave  - the adder cell itself; consumes the operands, drives results
// Signals :
//   a, b       addend bits
//   cin        carry in
//   in_valid   qualifies a/b/cin for capture into the registered outputs
//   sum, cout  combinational sum and carry out
//   gen, prop  carry generate (a&b) and propagate (a^b)
//   sum_q      registered sum
//   cout_q     registered carry out
//   out_valid  registered result valid
//   op_count   saturating count of accepted operations (CNT_W bits)

interface full_adder_cell_if #(
    parameter int CNT_W = 16
);
    logic             a;
    logic             b;
    logic             cin;
    logic             in_valid;
    logic             sum;
    logic             cout;
    logic             gen;
    logic             prop;
    logic             sum_q;
    logic             cout_q;
    logic             out_valid;
    logic [CNT_W-1:0] op_count;

    modport master (
        output a, b, cin, in_valid,
        input  sum, cout, gen, prop, sum_q, cout_q, out_valid, op_count
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, cout, gen, prop, sum_q, cout_q, out_valid, op_count
    );
endinterface

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - Single-bit full adder with registered, counted result.
//
// Purpose : combinational sum/carry plus generate/propagate for ripple or
//           lookahead chains, and a one-cycle registered, valid-qualified
//           copy of the result with a saturating accepted-operation counter.
// Ports   :
//   clk   - rising-edge clock
//   rst   - asynchronous, active-high reset of the registered outputs only
//   bus   - full_adder_cell_if.slave (operands in, results out)
// Parameters:
//   CNT_W - width of op_count (>= 1); must match the interface's CNT_W

module full_adder_cell #(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    full_adder_cell_if.slave        bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic a_i;
    logic b_i;
    logic cin_i;
    logic in_valid_i;

    logic gen_c;
    logic prop_c;
    logic sum_c;
    logic cout_c;

    logic             sum_q;
    logic             sum_d;
    logic             cout_q;
    logic             cout_d;
    logic             valid_q;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign a_i        = bus.a;
    assign b_i        = bus.b;
    assign cin_i      = bus.cin;
    assign in_valid_i = bus.in_valid;

    // Carry is expressed through gen/prop so the lookahead outputs and the
    // ripple carry can never disagree.
    assign gen_c  = a_i & b_i;
    assign prop_c = a_i ^ b_i;
    assign sum_c  = prop_c ^ cin_i;
    assign cout_c = gen_c | (prop_c & cin_i);

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (in_valid_i) begin
            sum_d   = sum_c;
            cout_d  = cout_c;
            valid_d = 1'b1;
            // Capture still happens at saturation; only the count stops.
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sum       = sum_c;
    assign bus.cout      = cout_c;
    assign bus.gen       = gen_c;
    assign bus.prop      = prop_c;
    assign bus.sum_q     = sum_q;
    assign bus.cout_q    = cout_q;
    assign bus.out_valid = valid_q;
    assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_full_adder_cell.sv
// tb/tb_full_adder_cell.sv - Self-checking bench for full_adder_cell.

module tb_full_adder_cell;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    full_adder_cell_if #(.CNT_W(16)) bus ();
    full_adder_cell #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    full_adder_cell_if #(.CNT_W(2)) sbus ();
    full_adder_cell #(.CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(sbus));

    logic [3:0] ra;
    logic [3:0] rb;
    logic       rcin;
    logic [3:0] rsum;
    logic [4:0] carry;

    assign carry[0] = rcin;

    for (genvar i = 0; i < 4; i++) begin : g_rc
        full_adder_cell_if #(.CNT_W(4)) rif ();
        full_adder_cell #(.CNT_W(4)) u_cell (.clk(clk), .rst(rst), .bus(rif));
        assign rif.a        = ra[i];
        assign rif.b        = rb[i];
        assign rif.cin      = carry[i];
        assign rif.in_valid = 1'b0;
        assign carry[i+1]   = rif.cout;
        assign rsum[i]      = rif.sum;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic sum;
        logic cout;
        logic gen;
        logic prop;
    } comb_vec_t;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic sum_q;
        logic cout_q;
    } seq_vec_t;

    comb_vec_t cvec[8];
    seq_vec_t  svec[4];

    // Reference: plain integer addition of the three bits.
    function automatic logic [1:0] ref_add(input logic a, input logic b, input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c);
        return 2'(s);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic a, input logic b, input logic c, input logic v);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        bus.in_valid = v;
    endtask

    logic [1:0] r2;
    logic       exp_sum_q;
    logic       exp_cout_q;
    logic       exp_valid;
    int         exp_cnt;
    logic       ta;
    logic       tb_b;
    logic       tc;
    logic       tv;

    initial begin
        cvec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cvec[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        cvec[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cvec[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        cvec[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cvec[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        cvec[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        cvec[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        svec[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        svec[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        svec[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        svec[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        sbus.a = 1'b0; sbus.b = 1'b0; sbus.cin = 1'b0; sbus.in_valid = 1'b0;
        ra = 4'h0; rb = 4'h0; rcin = 1'b0;

        // Reset asserted before any clock edge must clear the registers.
        #2 rst = 1'b1;
        #1;
        chk("rst_sum_q",     32'(bus.sum_q),     32'd0);
        chk("rst_cout_q",    32'(bus.cout_q),    32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_op_count",  32'(bus.op_count),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive combinational table, in_valid low.
        for (int i = 0; i < 8; i++) begin
            drive(cvec[i].a, cvec[i].b, cvec[i].cin, 1'b0);
            #1;
            chk($sformatf("comb_sum[%0d]", i),  32'(bus.sum),  32'(cvec[i].sum));
            chk($sformatf("comb_cout[%0d]", i), 32'(bus.cout), 32'(cvec[i].cout));
            chk($sformatf("comb_gen[%0d]", i),  32'(bus.gen),  32'(cvec[i].gen));
            chk($sformatf("comb_prop[%0d]", i), 32'(bus.prop), 32'(cvec[i].prop));
            chk($sformatf("comb_arith[%0d]", i), 32'({bus.cout, bus.sum}),
                32'(ref_add(cvec[i].a, cvec[i].b, cvec[i].cin)));
        end

        // Single registered capture, then hold.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("one_sum_q",     32'(bus.sum_q),     32'd1);
        chk("one_cout_q",    32'(bus.cout_q),    32'd1);
        chk("one_out_valid", 32'(bus.out_valid), 32'd1);
        chk("one_op_count",  32'(bus.op_count),  32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_out_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_sum_q",     32'(bus.sum_q),     32'd1);
        chk("hold_cout_q",    32'(bus.cout_q),    32'd1);
        chk("hold_op_count",  32'(bus.op_count),  32'd1);

        // Five ops, then asynchronous reset between edges.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'(i & 1), 1'b1);
            @(negedge clk);
        end
        chk("pre_rst_op_count", 32'(bus.op_count), 32'd5);
        #2 rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("async_sum_q",     32'(bus.sum_q),     32'd0);
        chk("async_cout_q",    32'(bus.cout_q),    32'd0);
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_op_count",  32'(bus.op_count),  32'd0);
        chk("async_comb_sum",  32'(bus.sum),       32'd1);
        chk("async_comb_cout", 32'(bus.cout),      32'd0);
        // Edge while reset held with in_valid high: nothing captured.
        @(negedge clk);
        chk("rst_hold_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_hold_op_count",  32'(bus.op_count),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_cap_valid", 32'(bus.out_valid), 32'd1);
        chk("first_cap_count", 32'(bus.op_count),  32'd1);
        chk("first_cap_sum_q", 32'(bus.sum_q),     32'd1);

        // Back-to-back stream.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(svec[i].a, svec[i].b, svec[i].cin, 1'b1);
            @(negedge clk);
            chk($sformatf("b2b_valid[%0d]", i),  32'(bus.out_valid), 32'd1);
            chk($sformatf("b2b_sum_q[%0d]", i),  32'(bus.sum_q),     32'(svec[i].sum_q));
            chk($sformatf("b2b_cout_q[%0d]", i), 32'(bus.cout_q),    32'(svec[i].cout_q));
        end
        chk("b2b_op_count", 32'(bus.op_count), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);

        // Saturation on the 2-bit counter instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ta = 1'($urandom_range(0, 1));
            tb_b = 1'($urandom_range(0, 1));
            tc = 1'($urandom_range(0, 1));
            sbus.a = ta; sbus.b = tb_b; sbus.cin = tc; sbus.in_valid = 1'b1;
            @(negedge clk);
            r2 = ref_add(ta, tb_b, tc);
            chk($sformatf("sat_count[%0d]", i), 32'(sbus.op_count), 32'((i + 1 > 3) ? 3 : i + 1));
            chk($sformatf("sat_valid[%0d]", i), 32'(sbus.out_valid), 32'd1);
            chk($sformatf("sat_q[%0d]", i), 32'({sbus.cout_q, sbus.sum_q}), 32'(r2));
        end
        sbus.in_valid = 1'b0;

        // Four-cell ripple chain against integer addition.
        ra = 4'hF; rb = 4'h1; rcin = 1'b0;
        #1;
        chk("ripple_F_1", 32'({carry[4], rsum}), 32'h10);
        ra = 4'h5; rb = 4'hA; rcin = 1'b1;
        #1;
        chk("ripple_5_A_1", 32'({carry[4], rsum}), 32'h10);
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rcin = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("ripple_rand[%0d]", i), 32'({carry[4], rsum}),
                32'(int'(ra) + int'(rb) + int'(rcin)));
        end

        // Randomized stream against a behavioural model.
        do_reset();
        exp_sum_q = 1'b0; exp_cout_q = 1'b0; exp_valid = 1'b0; exp_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            ta = 1'($urandom_range(0, 1));
            tb_b = 1'($urandom_range(0, 1));
            tc = 1'($urandom_range(0, 1));
            tv = 1'($urandom_range(0, 1));
            drive(ta, tb_b, tc, tv);
            #1;
            r2 = ref_add(ta, tb_b, tc);
            chk($sformatf("rnd_comb[%0d]", i), 32'({bus.cout, bus.sum}), 32'(r2));
            chk($sformatf("rnd_gp[%0d]", i), 32'({bus.gen, bus.prop}),
                32'({ta & tb_b, ta ^ tb_b}));
            if (tv) begin
                {exp_cout_q, exp_sum_q} = r2;
                exp_valid = 1'b1;
                exp_cnt = (exp_cnt + 1 > 65535) ? 65535 : exp_cnt + 1;
            end else begin
                exp_valid = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("rnd_q[%0d]", i), 32'({bus.cout_q, bus.sum_q}),
                32'({exp_cout_q, exp_sum_q}));
            chk($sformatf("rnd_valid[%0d]", i), 32'(bus.out_valid), 32'(exp_valid));
            chk($sformatf("rnd_count[%0d]", i), 32'(bus.op_count), 32'(exp_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_adder_cell.md
Name: full_adder_cell

Overview:
Single-bit full adder, the building block of the 4-bit ripple-carry adder. Four instances are chained carry-out to carry-in.
- Combinational sum/carry paths are purely combinational so the ripple chain has no added latency.
- Generate/propagate outputs are provided for lookahead use.
- A registered, valid-qualified copy of the result and a saturating operation counter support pipelined use and bench observability.

Parameters:
CNT_W, 16, width of the operation counter op_count (minimum 1)

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  reset, asynchronous, active-high
a  input  1  addend bit
b  input  1  addend bit
cin  input  1  carry in (from previous stage, or the adder's cin for bit 0)
in_valid  input  1  qualifies a/b/cin for capture into the registered outputs
sum  output  1  combinational sum bit
cout  output  1  combinational carry out
gen  output  1  carry generate, a AND b
prop  output  1  carry propagate, a XOR b
sum_q  output  1  registered sum
cout_q  output  1  registered carry out
out_valid  output  1  registered result valid
op_count  output  CNT_W  number of accepted operations, saturating

Behaviour:
Combinational outputs:
- sum = a XOR b XOR cin.
- cout = (a AND b) OR (cin AND (a XOR b)), which equals the majority of a, b, cin.
- gen = a AND b; prop = a XOR b; cout == gen OR (prop AND cin) at all times.
- No clock or reset dependence; valid independent of rst and in_valid.
- Zero latency; any input change propagates in the same delta/cycle.
- X/Z on an input may propagate to the dependent outputs; no masking.

Arithmetic rule:
- {cout, sum} == a + b + cin as a 2-bit unsigned value, for all 8 input combinations.

Registered outputs (rising edge of clk):
- in_valid=1: sum_q<=sum, cout_q<=cout, out_valid<=1.
- in_valid=0: sum_q and cout_q hold their previous values; out_valid<=0.
- Latency is exactly 1 cycle from in_valid to out_valid.
- out_valid pulses for one cycle per accepted cycle; back-to-back in_valid gives continuous out_valid with a new result each cycle.

op_count:
- Increments by 1 on every rising edge with in_valid=1.
- Saturates at 2^CNT_W-1 and holds there; no wrap.

Reset:
- rst asserted takes effect immediately, without waiting for a clock edge: sum_q=0, cout_q=0, out_valid=0, op_count=0.
- While rst is high, all registers hold their reset values regardless of clk or in_valid.
- Combinational outputs are unaffected by rst.
- Reset asserted mid-operation discards the pending capture; out_valid is 0 in the following cycle.
- First capture after reset occurs on the first rising edge with rst low and in_valid high.

Simultaneous events:
- rst has priority over in_valid at a clock edge.
- At saturation, in_valid still captures sum/cout and asserts out_valid; only op_count holds.

Test Plan:
1. Exhaustive combinational check, all 8 (a,b,cin) combinations: e.g. 0,0,0 -> sum=0,cout=0; 1,0,0 -> 1,0; 1,1,0 -> 0,1 with gen=1,prop=0; 1,1,1 -> 1,1; 0,1,1 -> 0,1 with gen=0,prop=1. Check {cout,sum}==a+b+cin for every row.
2. Registered path: rst pulse, then a=1,b=1,cin=1 with in_valid=1 for one cycle -> next cycle sum_q=1, cout_q=1, out_valid=1, op_count=1. The following cycle, with in_valid=0 -> out_valid=0 and sum_q/cout_q hold 1/1.
3. Async reset mid-run: after 5 accepted ops (op_count=5), assert rst between clock edges -> sum_q, cout_q, out_valid, op_count read 0 immediately, before any edge. Combinational sum/cout still track the inputs.
4. Back-to-back stream: in_valid=1 for 4 cycles with (a,b,cin) = (0,0,1), (1,0,1), (1,1,0), (0,0,0) -> out_valid high for 4 cycles with (sum_q,cout_q) = (1,0), (0,1), (0,1), (0,0); op_count=4.
5. Saturation: CNT_W=2, 5 accepted ops -> op_count stays at 3 after the third op; out_valid still asserts for the 4th and 5th ops.
6. 4-stage ripple chain of four cells: a=4'hF, b=4'h1, cin=0 -> sum=4'h0, final cout=1. a=4'h5, b=4'hA, cin=1 -> sum=4'h0, cout=1.
